// File: rtl/range_stats_finder.sv
// range_stats_finder
// Collects a session of WIDTH-bit samples between a go strobe and a finish
// strobe. Once the session ends it reports the range, minimum, maximum or
// midpoint (picked by sel) and a saturating sample count. A go while a session
// is running, or a finish outside a session, latches a sticky error that only
// reset clears.
//
// Ports:
//   clock       - system clock, all state changes on the rising edge
//   reset       - synchronous, active-high reset
//   data_in     - sample value (two's complement when SIGNED=1)
//   go          - session start; data_in on this cycle is the first sample
//   finish      - session end; data_in on this cycle is the last sample
//   sel         - 00 range, 01 min, 10 max, 11 midpoint
//   result      - selected statistic, 0 unless done
//   count       - samples in the last session (saturating), 0 unless done
//   done        - last session completed and results are valid
//   cnt_sat     - count saturated in the last session, 0 unless done
//   debug_error - sticky protocol error
module range_stats_finder #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int SIGNED    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 go,
    input  logic                 finish,
    input  logic [1:0]           sel,
    output logic [WIDTH-1:0]     result,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 done,
    output logic                 cnt_sat,
    output logic                 debug_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ERROR = 2'b10
    } state_t;

    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     minVal_q, minVal_d;
    logic [WIDTH-1:0]     maxVal_q, maxVal_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic                 sat_q,    sat_d;
    logic                 done_q,   done_d;
    logic                 err_q,    err_d;

    // Ordering test shared by the min and max trackers.
    function automatic logic isLess(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // State register and statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            minVal_q <= '0;
            maxVal_q <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            minVal_q <= minVal_d;
            maxVal_q <= maxVal_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: session start/accumulate/finish and protocol errors.
    always_comb begin
        state_d  = state_q;
        minVal_d = minVal_q;
        maxVal_d = maxVal_q;
        count_d  = count_q;
        sat_d    = sat_q;
        done_d   = done_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (finish) begin
                    state_d = ERROR;
                    done_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (go) begin
                    minVal_d = data_in;
                    maxVal_d = data_in;
                    count_d  = CNT_WIDTH'(1);
                    sat_d    = 1'b0;
                    done_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (go) begin
                    state_d = ERROR;
                    done_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    if (isLess(data_in, minVal_q)) begin
                        minVal_d = data_in;
                    end
                    if (isLess(maxVal_q, data_in)) begin
                        maxVal_d = data_in;
                    end
                    // A blocked increment is what marks the session as saturated.
                    if (count_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (finish) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ERROR: begin
                done_d = 1'b0;
                err_d  = 1'b1;
            end
            default: begin
                state_d = ERROR;
                done_d  = 1'b0;
                err_d   = 1'b1;
            end
        endcase
    end

    // Range and midpoint use one extra bit so neither the difference nor
    // the sum can overflow. For signed data the operands are sign-extended,
    // so taking bits [WIDTH:1] of the sum is an arithmetic shift right.
    logic             minExt;
    logic             maxExt;
    logic [WIDTH:0]   diffWide;
    logic [WIDTH:0]   sumWide;
    logic [WIDTH-1:0] stat;

    assign minExt   = (SIGNED != 0) ? minVal_q[WIDTH-1] : 1'b0;
    assign maxExt   = (SIGNED != 0) ? maxVal_q[WIDTH-1] : 1'b0;
    assign diffWide = {1'b0, maxVal_q} - {1'b0, minVal_q};
    assign sumWide  = {minExt, minVal_q} + {maxExt, maxVal_q};

    // Result decode follows sel combinationally; everything is masked to 0
    // unless a completed session is being reported.
    always_comb begin
        stat = '0;
        unique case (sel)
            2'b00: stat = diffWide[WIDTH-1:0];
            2'b01: stat = minVal_q;
            2'b10: stat = maxVal_q;
            2'b11: stat = sumWide[WIDTH:1];
            default: stat = '0;
        endcase
    end

    assign result      = done_q ? stat : '0;
    assign count       = done_q ? count_q : '0;
    assign cnt_sat     = done_q ? sat_q : 1'b0;
    assign done        = done_q;
    assign debug_error = err_q;

endmodule
